// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised 16x-oversampled UART receiver with
// majority-vote sampling, parity/frame/break detection and an FWFT FIFO.
module uart_rx_param #(
    parameter int    CLK_FREQ   = 100000000,
    parameter int    BAUD_RATE  = 115200,
    parameter int    OVERSAMPLE = 16,
    parameter int    DATA_BITS  = 8,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1,
    parameter int    FIFO_DEPTH = 16
) (
    input  logic                            clk_100m00,
    input  logic                            uart_rst,
    input  logic                            uart_rxd,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_parity_err,
    output logic                            rx_frame_err,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            rx_break,
    output logic                            rx_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int DIV   = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2)
                           / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_BITS + 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam bit               PAR_EN    = (PARITY != "NONE");
    localparam bit               PAR_ODD   = (PARITY == "ODD");

    if (DIV < 2 || OVERSAMPLE != 16 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY != "NONE" && PARITY != "EVEN" && PARITY != "ODD")) begin : g_bad_cfg
        $error("uart_rx_param: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_ARM, S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_100m00 or negedge uart_rst) begin
        if (!uart_rst) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic                 rxd_meta_q, rxd_s_q, rxd_prev_q;
    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           tick_q, tick_d;
    logic [3:0]           arm_q, arm_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 zero_q, zero_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 push_q, push_d;
    logic [ENT_W-1:0]     entry_q, entry_d;
    logic                 brk_q, brk_d;

    logic tick, maj, t7, t8, t9, t16;

    assign tick = (div_q == DIV_LAST);
    assign t7   = tick && (tick_q == 4'd6);
    assign t8   = tick && (tick_q == 4'd7);
    assign t9   = tick && (tick_q == 4'd8);
    assign t16  = tick && (tick_q == 4'd15);
    assign maj  = (s7_q & s8_q) | (s7_q & rxd_s_q) | (s8_q & rxd_s_q);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tick_d  = tick_q;
        arm_d   = arm_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        s7_d    = s7_q;
        s8_d    = s8_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push_d  = 1'b0;
        entry_d = entry_q;
        brk_d   = 1'b0;
        if (state_q != S_IDLE) begin
            div_d  = tick ? '0 : div_q + 1'b1;
            tick_d = tick ? tick_q + 4'd1 : tick_q;
        end
        if (t7) s7_d = rxd_s_q;
        if (t8) s8_d = rxd_s_q;
        unique case (state_q)
            S_ARM: begin
                if (!rxd_s_q) begin
                    arm_d = '0;
                end else if (tick) begin
                    arm_d = arm_q + 4'd1;
                    if (arm_q == 4'd15) state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                div_d  = '0;
                tick_d = '0;
                if (rxd_prev_q && !rxd_s_q) state_d = S_START;
            end
            S_START: begin
                if (t9 && maj) begin
                    state_d = S_IDLE;
                end else if (t16) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    zero_d  = 1'b1;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (t9) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~maj;
                end
                if (t16) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = PAR_EN ? S_PAR : S_STOP;
                        stop_d  = 1'b0;
                    end
                end
            end
            S_PAR: begin
                if (t9) begin
                    perr_d = (^shift_q) ^ maj ^ PAR_ODD;
                    zero_d = zero_q & ~maj;
                end
                if (t16) state_d = S_STOP;
            end
            S_STOP: begin
                if (t9) begin
                    // An all-zero frame with a low first stop bit is a break.
                    if (!stop_q && zero_q && !maj) begin
                        brk_d   = 1'b1;
                        arm_d   = '0;
                        state_d = S_ARM;
                    end else begin
                        ferr_d = ferr_q | ~maj;
                        if (stop_q == LAST_STOP) begin
                            push_d  = 1'b1;
                            entry_d = {ferr_q | ~maj, perr_q, shift_q};
                            state_d = S_IDLE;
                        end
                    end
                end else if (t16) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = S_ARM;
        endcase
    end

    always_ff @(posedge clk_100m00 or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= S_ARM;
            div_q      <= '0;
            tick_q     <= '0;
            arm_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            shift_q    <= '0;
            zero_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            entry_q    <= '0;
            brk_q      <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
            state_q    <= state_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            arm_q      <= arm_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            shift_q    <= shift_d;
            zero_q     <= zero_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            push_q     <= push_d;
            entry_q    <= entry_d;
            brk_q      <= brk_d;
        end
    end

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             pop, wr_en;
    logic [ENT_W-1:0] head;

    // A full FIFO still takes the new frame if the head leaves this cycle.
    always_comb begin
        pop   = rx_valid && rx_ready;
        wr_en = push_q && ((cnt_q != FULL_CNT) || pop);
        ovr_d = push_q && (cnt_q == FULL_CNT) && !pop;
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_100m00) begin
        if (wr_en) fifo_mem[wr_q] <= entry_q;
    end

    always_ff @(posedge clk_100m00 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    assign head          = fifo_mem[rd_q];
    assign rx_valid      = (cnt_q != '0);
    assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid & head[DATA_BITS];
    assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
    assign rx_break      = brk_q;
    assign rx_overrun    = ovr_q;
    assign fifo_count    = cnt_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param, one default-rate
// instance plus fast 8N1 and fast 8E1 instances sharing one reset.
module tb_uart_rx_param;

    localparam int FAST = 1562500;
    localparam int BD   = 864;
    localparam int BF   = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic rxd_d = 1'b1, rxd_f = 1'b1, rxd_p = 1'b1;
    logic rdy_d = 1'b0, rdy_f = 1'b0, rdy_p = 1'b0;
    logic [7:0] dat_d, dat_f, dat_p;
    logic pe_d, pe_f, pe_p, fe_d, fe_f, fe_p;
    logic vld_d, vld_f, vld_p, brk_d, brk_fo, brk_p, ovr_d, ovr_fo, ovr_p;
    logic [4:0] cnt_d, cnt_f, cnt_p;

    uart_rx_param u_def (
        .clk_100m00(clk), .uart_rst(rst_n), .uart_rxd(rxd_d),
        .rx_data(dat_d), .rx_parity_err(pe_d), .rx_frame_err(fe_d),
        .rx_valid(vld_d), .rx_ready(rdy_d), .rx_break(brk_d),
        .rx_overrun(ovr_d), .fifo_count(cnt_d)
    );

    uart_rx_param #(.BAUD_RATE(FAST)) u_fast (
        .clk_100m00(clk), .uart_rst(rst_n), .uart_rxd(rxd_f),
        .rx_data(dat_f), .rx_parity_err(pe_f), .rx_frame_err(fe_f),
        .rx_valid(vld_f), .rx_ready(rdy_f), .rx_break(brk_fo),
        .rx_overrun(ovr_fo), .fifo_count(cnt_f)
    );

    uart_rx_param #(.BAUD_RATE(FAST), .PARITY("EVEN")) u_par (
        .clk_100m00(clk), .uart_rst(rst_n), .uart_rxd(rxd_p),
        .rx_data(dat_p), .rx_parity_err(pe_p), .rx_frame_err(fe_p),
        .rx_valid(vld_p), .rx_ready(rdy_p), .rx_break(brk_p),
        .rx_overrun(ovr_p), .fifo_count(cnt_p)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int brk_f = 0;
    int ovr_f = 0;
    logic [9:0] q_d[$], q_f[$], q_p[$];
    logic [9:0] exp_d, exp_f, exp_p;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic no_exp(input string nm, input int act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got entry 0x%0h required none", nm, act);
    endtask

    // Scoreboard monitors: pop one expected entry per accepted head.
    always @(negedge clk) begin
        if (vld_d && rdy_d) begin
            if (q_d.size() == 0) no_exp("def_pop", {fe_d, pe_d, dat_d});
            else begin
                exp_d = q_d.pop_front();
                check("def_pop", {fe_d, pe_d, dat_d}, exp_d);
            end
        end
        if (vld_f && rdy_f) begin
            if (q_f.size() == 0) no_exp("fast_pop", {fe_f, pe_f, dat_f});
            else begin
                exp_f = q_f.pop_front();
                check("fast_pop", {fe_f, pe_f, dat_f}, exp_f);
            end
        end
        if (vld_p && rdy_p) begin
            if (q_p.size() == 0) no_exp("par_pop", {fe_p, pe_p, dat_p});
            else begin
                exp_p = q_p.pop_front();
                check("par_pop", {fe_p, pe_p, dat_p}, exp_p);
            end
        end
        if (brk_fo) brk_f++;
        if (ovr_fo) ovr_f++;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ln, input logic v);
        case (ln)
            0:       rxd_d = v;
            1:       rxd_f = v;
            default: rxd_p = v;
        endcase
    endtask

    task automatic send(input int ln, input logic [15:0] bits, input int nb, input int bt);
        for (int i = 0; i < nb; i++) begin
            drive(ln, bits[i]);
            wclk(bt);
        end
        drive(ln, 1'b1);
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stp);
        return {6'b0, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int b0;
        int o0;
        wclk(5);
        check("rst_valid", vld_f, 0);
        check("rst_count", cnt_f, 0);
        check("rst_data", dat_f, 0);
        check("rst_perr", pe_f, 0);
        check("rst_ferr", fe_f, 0);
        check("rst_break", brk_fo, 0);
        check("rst_overrun", ovr_fo, 0);
        check("rst_def_valid", vld_d, 0);
        check("rst_par_count", cnt_p, 0);
        rst_n = 1'b1;
        wclk(1000);
        rdy_d = 1'b1;
        rdy_f = 1'b1;
        rdy_p = 1'b1;

        // 8N1 at the default rate, with first-entry latency from the start edge
        q_d.push_back({2'b00, 8'hA5});
        lat = -1;
        fork
            send(0, f8n1(8'hA5, 1'b1), 10, BD);
            begin
                for (int c = 0; c < 12000; c++) begin
                    @(negedge clk);
                    if (vld_d) begin
                        lat = c;
                        break;
                    end
                end
            end
        join
        check_rng("def_latency", lat, 8150, 8350);

        // Even parity
        q_p.push_back({2'b01, 8'h03});
        send(2, f8e1(8'h03, 1'b1), 11, BF);
        q_p.push_back({2'b00, 8'h03});
        send(2, f8e1(8'h03, 1'b0), 11, BF);
        q_p.push_back({2'b00, 8'h07});
        send(2, f8e1(8'h07, 1'b1), 11, BF);
        wclk(2 * BF);
        check("par_count_drained", cnt_p, 0);

        // Frame error, then a break while that entry is held
        rdy_f = 1'b0;
        q_f.push_back({2'b10, 8'h55});
        send(1, f8n1(8'h55, 1'b0), 10, BF);
        wclk(2 * BF);
        check("ferr_count", cnt_f, 1);
        check("ferr_head_flag", fe_f, 1);
        b0 = brk_f;
        send(1, 16'h0000, 12, BF);
        wclk(3 * BF);
        check("break_pulses", brk_f - b0, 1);
        check("break_count_kept", cnt_f, 1);
        rdy_f = 1'b1;
        wclk(10);
        check("ferr_drained", cnt_f, 0);

        // Overrun: 17 frames into a 16-entry FIFO with no reads
        rdy_f = 1'b0;
        o0 = ovr_f;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) q_f.push_back({2'b00, 8'(i)});
            send(1, f8n1(8'(i), 1'b1), 10, BF);
        end
        wclk(BF);
        check("ovr_count_full", cnt_f, 16);
        check("ovr_pulses", ovr_f - o0, 1);
        check("ovr_head_stalled", dat_f, 0);
        rdy_f = 1'b1;
        wclk(40);
        check("ovr_drained", cnt_f, 0);

        // Short glitch is a false start
        b0 = brk_f;
        drive(1, 1'b0);
        wclk(12);
        drive(1, 1'b1);
        wclk(3 * BF);
        check("glitch_valid", vld_f, 0);
        check("glitch_count", cnt_f, 0);
        check("glitch_break", brk_f - b0, 0);
        q_f.push_back({2'b00, 8'h5A});
        send(1, f8n1(8'h5A, 1'b1), 10, BF);
        wclk(BF);
        check("glitch_then_frame", cnt_f, 0);

        // Reset mid-frame with two entries queued
        rdy_f = 1'b0;
        q_f.push_back({2'b00, 8'h11});
        send(1, f8n1(8'h11, 1'b1), 10, BF);
        q_f.push_back({2'b00, 8'h22});
        send(1, f8n1(8'h22, 1'b1), 10, BF);
        wclk(BF);
        check("pre_rst_count", cnt_f, 2);
        send(1, f8n1(8'h99, 1'b1), 5, BF);
        drive(1, 1'b0);
        wclk(3);
        rst_n = 1'b0;
        q_f.delete();
        #1;
        check("mid_rst_valid", vld_f, 0);
        check("mid_rst_count", cnt_f, 0);
        check("mid_rst_data", dat_f, 0);
        check("mid_rst_ferr", fe_f, 0);
        wclk(5);
        drive(1, 1'b1);
        rst_n = 1'b1;
        wclk(150);
        rdy_f = 1'b1;
        q_f.push_back({2'b00, 8'h3C});
        send(1, f8n1(8'h3C, 1'b1), 10, BF);
        wclk(BF);
        check("post_rst_count", cnt_f, 0);

        check("def_left", q_d.size(), 0);
        check("fast_left", q_f.size(), 0);
        check("par_left", q_p.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
